cbm2_mem_loader: RTL

Feeds the SDRAM request port of the CBM-II core during the I/O slots that `cbm2_main` leaves free (`io_cycle` high). It accepts the HPS ioctl byte stream for ROM/PRG downloads and a memory-erase request, and turns each into single-byte SDRAM writes. Each write is issued only inside an `io_cycle` slot, so CPU/video timing is never disturbed. The top level selects this block's request outputs onto the SDRAM `addr`/`ce`/`we`/`din` inputs whenever `io_cycle` is high.

---
 rtl/cbm2_pkg.sv | 29 ++
 rtl/cbm2_mem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cbm2_pkg.sv
// cbm2_pkg: shared definitions for the CBM-II memory loader and any later
// erase/verify logic that must reproduce the same fill pattern.
package cbm2_pkg;

   // Default SDRAM byte-address width.
   localparam int ADDR_W = 25;

   // Loader states: a pending download byte and an active erase sweep are
   // independent, so the four states cover every combination of the two.
   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_PEND       = 2'd1,
      S_ERASE      = 2'd2,
      S_ERASE_PEND = 2'd3
   } loader_state_t;

   // Erase fill byte: 64-byte stripes alternating 00/FF, selected by address
   // bit 6 (the only address bit that matters, so only it is passed in).
   function automatic logic [7:0] erase_fill(input logic addr_b6);
      logic [7:0] fill;
      if (addr_b6) begin
         fill = 8'hFF;
      end else begin
         fill = 8'h00;
      end
      return fill;
   endfunction

endpackage

// File: rtl/cbm2_mem_loader.sv
// cbm2_mem_loader: turns HPS download bytes and erase sweeps into single-byte
// SDRAM writes, issued only on the first cycle of each free io_cycle slot so
// CPU/video SDRAM timing is never disturbed.
module cbm2_mem_loader #(
   parameter int ADDR_W = cbm2_pkg::ADDR_W
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              io_cycle,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              erase_req,
   input  logic [ADDR_W-1:0] erase_top,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [7:0]        mem_din,
   output logic              erasing,
   output logic              busy
);
   import cbm2_pkg::*;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   loader_state_t       r_state;
   loader_state_t       w_state_nxt;
   logic                r_io_cycle_d;
   logic [ADDR_W-1:0]   r_pend_addr;
   logic [ADDR_W-1:0]   w_pend_addr_nxt;
   logic [7:0]          r_pend_data;
   logic [7:0]          w_pend_data_nxt;
   logic [ADDR_W-1:0]   r_erase_ptr;
   logic [ADDR_W-1:0]   w_erase_ptr_nxt;
   logic [ADDR_W-1:0]   r_erase_lim;
   logic [ADDR_W-1:0]   w_erase_lim_nxt;
   logic                r_mem_ce;
   logic                r_mem_we;
   logic                w_mem_req_nxt;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [ADDR_W-1:0]   w_mem_addr_nxt;
   logic [7:0]          r_mem_din;
   logic [7:0]          w_mem_din_nxt;

   logic w_slot;
   logic w_pending;
   logic w_erasing;
   logic w_issue_byte;
   logic w_issue_erase;
   logic w_erase_last;
   logic w_pend_keep;
   logic w_erase_keep;
   logic w_unused;

   // The download flag does not gate anything: a latched byte must still be
   // written after the download ends.
   assign w_unused = ioctl_download;

   // A slot is the first cycle of an io_cycle high period; issuing there and
   // registering the request keeps the write inside the same period.
   assign w_slot        = io_cycle & ~r_io_cycle_d;
   assign w_pending     = (r_state == S_PEND) | (r_state == S_ERASE_PEND);
   assign w_erasing     = (r_state == S_ERASE) | (r_state == S_ERASE_PEND);
   assign w_issue_byte  = w_slot & w_pending;
   assign w_issue_erase = w_slot & ~w_pending & w_erasing;
   // Termination by equality so a limit of all-ones never needs the pointer to wrap.
   assign w_erase_last  = w_issue_erase & (r_erase_ptr == r_erase_lim);

   // A byte stays pending unless issued now; a new strobe always makes one pending.
   assign w_pend_keep  = (w_pending & ~w_issue_byte) | ioctl_wr;
   // A new erase request (re)starts the sweep; otherwise it runs until its last write.
   assign w_erase_keep = erase_req | (w_erasing & ~w_erase_last);

   assign ioctl_wait = ioctl_wr | w_pending;
   assign erasing    = w_erasing;
   assign busy       = (r_state != S_IDLE);
   assign mem_ce     = r_mem_ce;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_din    = r_mem_din;

   // Next-state decode from the pending-byte and erase-active flags.
   always_comb begin
      w_state_nxt = S_IDLE;
      case ({w_erase_keep, w_pend_keep})
         2'b00:   w_state_nxt = S_IDLE;
         2'b01:   w_state_nxt = S_PEND;
         2'b10:   w_state_nxt = S_ERASE;
         2'b11:   w_state_nxt = S_ERASE_PEND;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath next values: byte latch, erase pointer/limit and the write request.
   always_comb begin
      w_pend_addr_nxt = r_pend_addr;
      w_pend_data_nxt = r_pend_data;
      w_erase_ptr_nxt = r_erase_ptr;
      w_erase_lim_nxt = r_erase_lim;
      w_mem_req_nxt   = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_din_nxt   = r_mem_din;

      if (ioctl_wr) begin
         w_pend_addr_nxt = load_base + ioctl_addr;
         w_pend_data_nxt = ioctl_dout;
      end else begin
         w_pend_addr_nxt = r_pend_addr;
         w_pend_data_nxt = r_pend_data;
      end

      if (erase_req) begin
         w_erase_ptr_nxt = ADDR_ZERO;
         w_erase_lim_nxt = erase_top;
      end else if (w_issue_erase & ~w_erase_last) begin
         w_erase_ptr_nxt = r_erase_ptr + ADDR_ONE;
      end else begin
         w_erase_ptr_nxt = r_erase_ptr;
      end

      if (w_issue_byte) begin
         w_mem_req_nxt  = 1'b1;
         w_mem_addr_nxt = r_pend_addr;
         w_mem_din_nxt  = r_pend_data;
      end else if (w_issue_erase) begin
         w_mem_req_nxt  = 1'b1;
         w_mem_addr_nxt = r_erase_ptr;
         w_mem_din_nxt  = erase_fill(r_erase_ptr[6]);
      end else begin
         w_mem_req_nxt  = 1'b0;
      end
   end

   // State register; reset abandons any pending byte or erase immediately.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered SDRAM request outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_io_cycle_d <= 1'b0;
         r_pend_addr  <= ADDR_ZERO;
         r_pend_data  <= 8'h00;
         r_erase_ptr  <= ADDR_ZERO;
         r_erase_lim  <= ADDR_ZERO;
         r_mem_ce     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= ADDR_ZERO;
         r_mem_din    <= 8'h00;
      end else begin
         r_io_cycle_d <= io_cycle;
         r_pend_addr  <= w_pend_addr_nxt;
         r_pend_data  <= w_pend_data_nxt;
         r_erase_ptr  <= w_erase_ptr_nxt;
         r_erase_lim  <= w_erase_lim_nxt;
         r_mem_ce     <= w_mem_req_nxt;
         r_mem_we     <= w_mem_req_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_din    <= w_mem_din_nxt;
      end
   end

endmodule
